// File: rtl/spi_master_core_pkg.sv
// Shared types for the SPI master engine: FSM states, CPOL/CPHA modes, select-index sizing.
package spi_pkg;

  typedef enum logic [1:0] {IDLE, SETUP, SHIFT, HOLD} spi_state_e;

  // Encoded as {cpol, cpha}
  typedef enum logic [1:0] {MODE0, MODE1, MODE2, MODE3} spi_mode_e;

  function automatic int ss_idx_w(input int num_ss);
    return (num_ss > 1) ? $clog2(num_ss) : 1;
  endfunction

endpackage

// File: rtl/spi_master_core_if.sv
// Word handshake between the register/bus side and the SPI shift engine.
interface spi_master_core_if #(parameter int DATA_WIDTH = 8) ();
  logic                  tx_valid;
  logic [DATA_WIDTH-1:0] tx_data;
  logic                  tx_ready;
  logic                  rx_valid;
  logic [DATA_WIDTH-1:0] rx_data;

  modport master (output tx_valid, tx_data, input tx_ready, rx_valid, rx_data);
  modport slave  (input tx_valid, tx_data, output tx_ready, rx_valid, rx_data);
endinterface

// File: rtl/spi_master_core_clk_div.sv
// Half-period tick generator: fires every div_i+1 enabled cycles, reloaded on clear.
module spi_clk_div #(
  parameter int DIV_WIDTH = 8
) (
  input  logic                 clk_in,
  input  logic                 rstn_in,
  input  logic                 en_i,
  input  logic                 clr_i,
  input  logic [DIV_WIDTH-1:0] div_i,
  output logic                 tick_o
);
  logic [DIV_WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)     cnt_d = div_i;
    else if (en_i) cnt_d = (cnt_q == '0) ? div_i : cnt_q - 1'b1;
  end

  always_ff @(posedge clk_in) begin
    if (!rstn_in) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

  assign tick_o = en_i && !clr_i && (cnt_q == '0);
endmodule

// File: rtl/spi_master_core.sv
// SPI master shift/timing engine: one DATA_WIDTH word per handshake, any CPOL/CPHA mode.
module spi_master_core import spi_pkg::*; #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_SS     = 4,
  parameter int DIV_WIDTH  = 8,
  localparam int SSW       = ss_idx_w(NUM_SS)
) (
  input  logic                 clk_in,
  input  logic                 rstn_in,
  input  logic                 cfg_cpol,
  input  logic                 cfg_cpha,
  input  logic                 cfg_lsb_first,
  input  logic [DIV_WIDTH-1:0] cfg_clk_div,
  input  logic [SSW-1:0]       cfg_ss_sel,
  spi_master_core_if.slave     bus,
  output logic                 busy,
  output logic                 sck_out,
  output logic                 mosi_out,
  input  logic                 miso_in,
  output logic [NUM_SS-1:0]    ss_n_out
);
  localparam int            EW        = $clog2(2*DATA_WIDTH+1);
  localparam logic [EW-1:0] LAST_EDGE = EW'(2*DATA_WIDTH);

  spi_state_e            state_q, state_d;
  spi_mode_e             mode_q, mode_d;
  logic                  lsb_q, lsb_d;
  logic [DIV_WIDTH-1:0]  div_q, div_d;
  logic [SSW-1:0]        sel_q, sel_d;
  logic [DATA_WIDTH-1:0] tx_sr_q, tx_sr_d, rx_sr_q, rx_sr_d, rx_data_q, rx_data_d;
  logic [EW-1:0]         edge_cnt_q, edge_cnt_d;
  logic                  sck_q, sck_d, mosi_q, mosi_d, rx_valid_q, rx_valid_d;
  logic                  tick, toggle, cpha;

  function automatic logic head(input logic [DATA_WIDTH-1:0] v, input logic lsb);
    return lsb ? v[0] : v[DATA_WIDTH-1];
  endfunction

  function automatic logic [DATA_WIDTH-1:0] shift_out(input logic [DATA_WIDTH-1:0] v,
                                                      input logic lsb);
    return lsb ? {1'b0, v[DATA_WIDTH-1:1]} : {v[DATA_WIDTH-2:0], 1'b0};
  endfunction

  assign busy = (state_q != IDLE);
  assign cpha = (mode_q == MODE1) || (mode_q == MODE3);

  // While idle the counter preloads the live divider so SETUP already counts the latched value
  spi_clk_div #(.DIV_WIDTH(DIV_WIDTH)) u_clk_div (
    .clk_in (clk_in),
    .rstn_in(rstn_in),
    .en_i   (busy),
    .clr_i  (!busy),
    .div_i  (busy ? div_q : cfg_clk_div),
    .tick_o (tick)
  );

  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    lsb_d      = lsb_q;
    div_d      = div_q;
    sel_d      = sel_q;
    tx_sr_d    = tx_sr_q;
    rx_sr_d    = rx_sr_q;
    edge_cnt_d = edge_cnt_q;
    sck_d      = sck_q;
    mosi_d     = mosi_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    toggle     = 1'b0;
    case (state_q)
      IDLE: if (bus.tx_valid) begin
        state_d    = SETUP;
        mode_d     = spi_mode_e'({cfg_cpol, cfg_cpha});
        lsb_d      = cfg_lsb_first;
        div_d      = cfg_clk_div;
        sel_d      = cfg_ss_sel;
        sck_d      = cfg_cpol;
        edge_cnt_d = '0;
        rx_sr_d    = '0;
        tx_sr_d    = bus.tx_data;
        mosi_d     = 1'b0;
        // CPHA=0 must present the first bit before the first (sampling) edge
        if (!cfg_cpha) begin
          mosi_d  = head(bus.tx_data, cfg_lsb_first);
          tx_sr_d = shift_out(bus.tx_data, cfg_lsb_first);
        end
      end
      SETUP: if (tick) begin
        state_d = SHIFT;
        toggle  = 1'b1;
      end
      SHIFT: if (tick) begin
        if (edge_cnt_q == LAST_EDGE) state_d = HOLD;
        else                         toggle  = 1'b1;
      end
      HOLD: if (tick) begin
        state_d    = IDLE;
        rx_valid_d = 1'b1;
        rx_data_d  = rx_sr_q;
        mosi_d     = 1'b0;
      end
      default: state_d = IDLE;
    endcase

    // Odd edge count = leading edge; the driving edge is the one whose parity matches CPHA
    if (toggle) begin
      sck_d      = ~sck_q;
      edge_cnt_d = edge_cnt_q + 1'b1;
      if (edge_cnt_d[0] == cpha) begin
        if (edge_cnt_d != LAST_EDGE) begin
          mosi_d  = head(tx_sr_q, lsb_q);
          tx_sr_d = shift_out(tx_sr_q, lsb_q);
        end
      end else begin
        rx_sr_d = lsb_q ? {miso_in, rx_sr_q[DATA_WIDTH-1:1]}
                        : {rx_sr_q[DATA_WIDTH-2:0], miso_in};
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rstn_in) begin
      state_q    <= IDLE;
      mode_q     <= MODE0;
      lsb_q      <= 1'b0;
      div_q      <= '0;
      sel_q      <= '0;
      tx_sr_q    <= '0;
      rx_sr_q    <= '0;
      edge_cnt_q <= '0;
      sck_q      <= 1'b0;
      mosi_q     <= 1'b0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      lsb_q      <= lsb_d;
      div_q      <= div_d;
      sel_q      <= sel_d;
      tx_sr_q    <= tx_sr_d;
      rx_sr_q    <= rx_sr_d;
      edge_cnt_q <= edge_cnt_d;
      sck_q      <= sck_d;
      mosi_q     <= mosi_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
    end
  end

  // Out-of-range select indices match no output, so the word runs with every select high
  always_comb begin
    ss_n_out = '1;
    for (int i = 0; i < NUM_SS; i++)
      if (busy && sel_q == SSW'(i)) ss_n_out[i] = 1'b0;
  end

  assign bus.tx_ready = !busy;
  assign bus.rx_valid = rx_valid_q;
  assign bus.rx_data  = rx_data_q;
  assign sck_out      = busy ? sck_q : cfg_cpol;
  assign mosi_out     = mosi_q;
endmodule

// File: tb/tb_spi_master_core.sv
// Bench for spi_master_core: vector table + random transfers against a behavioural SPI slave/timing model.
module tb_spi_master_core;
  logic       clk_in = 1'b0;
  logic       rstn_in;
  logic       cfg_cpol, cfg_cpha, cfg_lsb_first;
  logic [7:0] cfg_clk_div;
  logic [1:0] cfg_ss_sel;
  logic       busy, sck_out, mosi_out, miso_in;
  logic [3:0] ss_n_out;
  logic       loop_en, miso_bit;
  int         vectors = 0;
  int         miscompares = 0;

  spi_master_core_if #(.DATA_WIDTH(8)) bus ();

  spi_master_core #(.DATA_WIDTH(8), .NUM_SS(4), .DIV_WIDTH(8)) dut (
    .clk_in(clk_in), .rstn_in(rstn_in), .cfg_cpol(cfg_cpol), .cfg_cpha(cfg_cpha),
    .cfg_lsb_first(cfg_lsb_first), .cfg_clk_div(cfg_clk_div), .cfg_ss_sel(cfg_ss_sel),
    .bus(bus), .busy(busy), .sck_out(sck_out), .mosi_out(mosi_out), .miso_in(miso_in),
    .ss_n_out(ss_n_out)
  );

  assign miso_in = loop_en ? mosi_out : miso_bit;
  always #5 clk_in = ~clk_in;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  typedef struct {
    string      nm;
    logic       cpol, cpha, lsb;
    logic [7:0] div;
    logic [1:0] sel;
    logic [7:0] tx, miso;
    logic       loop;
    logic [7:0] exp_rx;
    bit         perturb;
  } vec_t;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Timing is predicted from half-period arithmetic: cycle k lies in half-period (k-1)/(div+1),
  // 0 = setup, 1..16 = shift, 17 = hold, and the word completes one cycle after that.
  task automatic run_xfer(input vec_t v);
    int         L, e, ns, nd, rxv_at, npulse, bad_ss, bad_sck, bad_rdy, h, w;
    logic [7:0] cap;
    logic [3:0] exp_ss;
    logic       prev, exp_sck, lead;
    @(negedge clk_in);
    cfg_cpol = v.cpol; cfg_cpha = v.cpha; cfg_lsb_first = v.lsb;
    cfg_clk_div = v.div; cfg_ss_sel = v.sel;
    bus.tx_data = v.tx; loop_en = v.loop; miso_bit = 1'b0;
    w = 0;
    while (bus.tx_ready !== 1'b1 && w < 200) begin @(negedge clk_in); w++; end
    if (w == 200) begin check({v.nm, ":idle_timeout"}, 0, 1); return; end
    bus.tx_valid = 1'b1;
    @(posedge clk_in);
    L = 1 + 18 * (int'(v.div) + 1);
    e = 0; ns = 0; nd = 0; rxv_at = -1; npulse = 0;
    bad_ss = 0; bad_sck = 0; bad_rdy = 0; cap = '0; prev = v.cpol;
    for (int k = 1; k <= L + 2; k++) begin
      @(negedge clk_in);
      if (k == 1) bus.tx_valid = 1'b0;
      if (v.perturb && k == 10) begin cfg_cpol = ~v.cpol; cfg_clk_div = 8'd5; end
      exp_ss = (k < L) ? ~(4'b0001 << v.sel) : 4'hF;
      if (ss_n_out !== exp_ss) bad_ss++;
      if (k < L) begin
        h = (k - 1) / (int'(v.div) + 1);
        exp_sck = v.cpol ^ (h >= 1 && h <= 16 && (h % 2) == 1);
        if (sck_out !== exp_sck) bad_sck++;
      end
      if (bus.tx_ready !== (k >= L) || busy !== (k < L)) bad_rdy++;
      if (bus.rx_valid === 1'b1) begin
        npulse++;
        if (rxv_at < 0) rxv_at = k;
      end
      // Behavioural slave: presents/captures bit j at position lsb ? j : 7-j
      if (k == 1 && !v.cpha) begin miso_bit = v.miso[v.lsb ? 0 : 7]; nd = 1; end
      if (k < L && sck_out !== prev) begin
        e++;
        lead = (e % 2) == 1;
        if (lead != v.cpha) begin
          if (ns < 8) cap[v.lsb ? ns : 7 - ns] = mosi_out;
          ns++;
        end else begin
          if (nd < 8) miso_bit = v.miso[v.lsb ? nd : 7 - nd];
          nd++;
        end
      end
      prev = sck_out;
    end
    check({v.nm, ":ss_pattern"}, bad_ss, 0);
    check({v.nm, ":sck_wave"}, bad_sck, 0);
    check({v.nm, ":ready_busy"}, bad_rdy, 0);
    check({v.nm, ":rx_valid_cycle"}, rxv_at, L);
    check({v.nm, ":rx_valid_pulses"}, npulse, 1);
    check({v.nm, ":rx_data"}, bus.rx_data, v.exp_rx);
    check({v.nm, ":mosi_bits"}, cap, v.tx);
    check({v.nm, ":sck_edges"}, e, 16);
  endtask

  initial begin
    vec_t       tbl[6];
    vec_t       rv;
    int         e, np, p1, p2, nhigh;
    logic       prev;
    logic [7:0] r1, r2;

    tbl[0] = '{"m0_a5_loop",   0, 0, 0, 8'd1, 2'd0, 8'hA5, 8'h00, 1, 8'hA5, 0};
    tbl[1] = '{"m3_3c_slave",  1, 1, 0, 8'd0, 2'd2, 8'h96, 8'h3C, 0, 8'h3C, 0};
    tbl[2] = '{"m1_lsb_01",    0, 1, 1, 8'd1, 2'd1, 8'h01, 8'h00, 1, 8'h01, 0};
    tbl[3] = '{"m2_lsb_slave", 1, 0, 1, 8'd2, 2'd3, 8'h5A, 8'hC3, 0, 8'hC3, 0};
    tbl[4] = '{"m0_cfg_change",0, 0, 0, 8'd1, 2'd0, 8'h6D, 8'h00, 1, 8'h6D, 1};
    tbl[5] = '{"m2_new_cfg",   1, 0, 0, 8'd5, 2'd0, 8'h81, 8'h7E, 0, 8'h7E, 0};

    rstn_in = 1'b0; cfg_cpol = 1'b1; cfg_cpha = 1'b0; cfg_lsb_first = 1'b0;
    cfg_clk_div = 8'd0; cfg_ss_sel = 2'd0; bus.tx_valid = 1'b0; bus.tx_data = 8'h00;
    loop_en = 1'b0; miso_bit = 1'b0;
    repeat (3) @(posedge clk_in);
    @(negedge clk_in);
    check("rst:tx_ready", bus.tx_ready, 1);
    check("rst:busy", busy, 0);
    check("rst:rx_valid", bus.rx_valid, 0);
    check("rst:rx_data", bus.rx_data, 0);
    check("rst:ss_n", ss_n_out, 4'hF);
    check("rst:mosi", mosi_out, 0);
    check("rst:sck_cpol1", sck_out, 1);
    cfg_cpol = 1'b0;
    #1;
    check("rst:sck_cpol0", sck_out, 0);
    @(negedge clk_in);
    rstn_in = 1'b1;

    for (int i = 0; i < 6; i++) run_xfer(tbl[i]);

    // Reset on the 5th SCK edge of a mode-2 word: abort cleanly, no rx_valid
    @(negedge clk_in);
    cfg_cpol = 1'b1; cfg_cpha = 1'b0; cfg_lsb_first = 1'b0; cfg_clk_div = 8'd1;
    cfg_ss_sel = 2'd1; bus.tx_data = 8'hA5; loop_en = 1'b1; bus.tx_valid = 1'b1;
    @(posedge clk_in);
    e = 0; prev = 1'b1;
    for (int w = 0; w < 100 && e < 5; w++) begin
      @(negedge clk_in);
      if (w == 0) bus.tx_valid = 1'b0;
      if (sck_out !== prev) e++;
      prev = sck_out;
    end
    check("midrst:edge5_reached", e, 5);
    rstn_in = 1'b0;
    @(posedge clk_in);
    @(negedge clk_in);
    check("midrst:busy", busy, 0);
    check("midrst:ss_n", ss_n_out, 4'hF);
    check("midrst:sck", sck_out, 1);
    check("midrst:mosi", mosi_out, 0);
    check("midrst:tx_ready", bus.tx_ready, 1);
    check("midrst:rx_valid", bus.rx_valid, 0);
    rstn_in = 1'b1;
    np = 0;
    repeat (40) begin @(negedge clk_in); if (bus.rx_valid === 1'b1) np++; end
    check("midrst:no_rx_pulse", np, 0);
    run_xfer('{"post_reset", 0, 0, 0, 8'd1, 2'd3, 8'hE7, 8'h00, 1, 8'hE7, 0});

    // Back-to-back words with tx_valid held high
    @(negedge clk_in);
    cfg_cpol = 1'b0; cfg_cpha = 1'b0; cfg_lsb_first = 1'b0; cfg_clk_div = 8'd1;
    cfg_ss_sel = 2'd1; loop_en = 1'b1; bus.tx_data = 8'h3A; bus.tx_valid = 1'b1;
    @(posedge clk_in);
    p1 = -1; p2 = -1; nhigh = 0; r1 = '0; r2 = '0;
    for (int k = 1; k <= 120 && p2 < 0; k++) begin
      @(negedge clk_in);
      if (k == 1) bus.tx_data = 8'hC5;
      if (bus.rx_valid === 1'b1) begin
        if (p1 < 0) begin p1 = k; r1 = bus.rx_data; end
        else begin p2 = k; r2 = bus.rx_data; bus.tx_valid = 1'b0; end
      end
      if (p2 < 0 && ss_n_out === 4'hF) nhigh++;
    end
    bus.tx_valid = 1'b0;
    check("b2b:first_rx_cycle", p1, 37);
    check("b2b:rx_spacing", p2 - p1, 37);
    check("b2b:first_rx_data", r1, 8'h3A);
    check("b2b:second_rx_data", r2, 8'hC5);
    check("b2b:ss_idle_cycles", nhigh, 1);
    repeat (3) @(negedge clk_in);
    check("b2b:no_third_word", busy, 0);

    for (int i = 0; i < 12; i++) begin
      rv.nm      = $sformatf("rand%0d", i);
      rv.cpol    = 1'($urandom_range(0, 1));
      rv.cpha    = 1'($urandom_range(0, 1));
      rv.lsb     = 1'($urandom_range(0, 1));
      rv.div     = 8'($urandom_range(0, 3));
      rv.sel     = 2'($urandom_range(0, 3));
      rv.tx      = 8'($urandom);
      rv.miso    = 8'($urandom);
      rv.loop    = 1'($urandom_range(0, 1));
      rv.exp_rx  = rv.loop ? rv.tx : rv.miso;
      rv.perturb = 0;
      run_xfer(rv);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
